mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the pipelined RV32I core, directly downstream of the execute-stage ALU. Each cycle it consumes one instruction slot from the EX/MEM boundary: ALU result, store data, and control. Loads and stores use the ALU result as the byte address for a data-memory handshake. All other instructions pass the ALU result through to writeback. While a memory access is outstanding it stalls upstream stages, and it formats load data (alignment, sign/zero extension) before registering it into the MEM/WB slot.

## Interface
- ADDR_CHECK, default 1: 1 enables misalignment/illegal-funct3 trapping; 0 forces the low address bits to the natural alignment and never traps.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  EX/MEM slot holds a valid instruction
- ex_alu_out  in  32  ALU result (address for load/store, result otherwise)
- ex_rs2  in  32  store data
- ex_funct3  in  3  RV32I funct3
- ex_load  in  1  instruction is a load
- ex_store  in  1  instruction is a store (never high with ex_load)
- ex_wb_en  in  1  non-memory instruction writes rd
- ex_rd  in  5  destination register
- stall_out  out  1  upstream must hold EX/MEM contents
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_mbe  out  4  write byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_rdata  in  32  read data, valid when dmem_resp
- dmem_resp  in  1  one-cycle completion pulse
- wb_valid  out  1  MEM/WB slot valid
- wb_we  out  1  register write enable
- wb_rd  out  5  destination register
- wb_data  out  32  writeback value
- misalign_err  out  1  one-cycle pulse with the wb_valid of a trapped access

## Operation
- The FSM has two states: IDLE and ACCESS. Reset puts it in IDLE.
- IDLE, ex_valid with no memory op:
  - The next edge loads the WB slot: wb_valid=1, wb_data=ex_alu_out, wb_we=ex_wb_en&(ex_rd!=0).
- IDLE, ex_valid with a legal, aligned memory op:
  - The next edge registers addr, mbe, wdata, funct3, rd and load/store into request registers.
  - The FSM moves to ACCESS. The WB slot is loaded with wb_valid=0 (bubble).
- ACCESS:
  - dmem_read or dmem_write is held high from the registers until dmem_resp.
  - On the edge ending the dmem_resp cycle, the FSM returns to IDLE and the WB slot is loaded.
  - Load: wb_we=(rd!=0), wb_data is the formatted rdata.
  - Store: wb_we=0, wb_data=0.
- Offset is off=addr[1:0]. For stores:
  - funct3 000 (sb): mbe=1<<off.
  - funct3 001 (sh): mbe=3<<off.
  - funct3 010 (sw): mbe=4'hF.
  - wdata=ex_rs2<<(8*off).
  - dmem_mbe=0 during reads.
- For loads, select the byte/half at off from rdata:
  - 000 (lb): sign-extend byte.
  - 100 (lbu): zero-extend byte.
  - 001 (lh): sign-extend half.
  - 101 (lhu): zero-extend half.
  - 010 (lw): whole word.
- Trap cases (ADDR_CHECK=1):
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load funct3 011/110/111 or store funct3 other than 000/001/010.
  - Behaviour: no dmem request, no stall; the next edge loads wb_valid=1, wb_we=0, misalign_err=1.
- ex_valid=0 in IDLE: the next edge loads wb_valid=0, wb_we=0, misalign_err=0.
- dmem_resp while in IDLE is ignored.
- stall_out = (IDLE & ex_valid & legal memop) | (ACCESS & !dmem_resp).

## Timing
- Reset values: state IDLE; stall_out=0 for all inputs while rst is held; all registered outputs 0 (wb_*, misalign_err, dmem_read, dmem_write, dmem_mbe, dmem_wdata, dmem_addr).
- Reset assertion mid-ACCESS clears dmem_read/dmem_write immediately (asynchronously) and abandons the transaction.
- Non-memory latency: 1 cycle from ex_valid to wb_valid.
- Memory op latency: request visible 1 cycle after acceptance; wb_valid appears the cycle after dmem_resp. Minimum is 2 cycles (resp in the first ACCESS cycle).
- stall_out drops in the dmem_resp cycle, so upstream advances on the same edge that loads the WB slot. There are no dead cycles between back-to-back memory ops.
- Upstream holds every ex_* input stable while stall_out=1. This block does not re-sample them in ACCESS.
- The WB slot outputs are registered and change only on clock edges.

## Test plan
- ALU passthrough: ex_alu_out=0x0000_1234, ex_wb_en=1, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234. Repeat with rd=0 -> wb_we=0.
- lb sign extend: addr=0x1003, rdata=0x80FF_FF7F, dmem_resp 3 cycles after request -> dmem_addr=0x1000, dmem_read held 3 cycles, stall_out high throughout, wb_data=0xFFFF_FF80.
- lhu/lh: addr=0x2002, rdata=0x9ABC_0000 -> lhu gives 0x0000_9ABC, lh gives 0xFFFF_9ABC.
- Stores:
  - sb addr=0x3001, rs2=0xAA -> mbe=4'b0010, wdata=0x0000_AA00.
  - sh addr=0x3002, rs2=0x1234 -> mbe=4'b1100, wdata=0x1234_0000.
  - sw -> mbe=4'hF. wb_we=0 in all cases.
- Misalignment: lw addr=0x4002 -> no dmem_read, stall_out=0, next cycle wb_valid=1, wb_we=0, misalign_err=1 for exactly one cycle. With ADDR_CHECK=0 -> a read at 0x4000 is issued instead.
- Reset mid-access: assert rst during ACCESS before dmem_resp -> dmem_read drops immediately and all outputs read 0. After release, a stray dmem_resp causes no wb_valid.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: passes ALU results through to writeback,
// runs a single outstanding data-memory access for loads/stores, stalls upstream
// while that access is pending, and formats load data before the MEM/WB slot.
module mem_stage #(
  parameter bit ADDR_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rs2,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic        ex_wb_en,
  input  logic [4:0]  ex_rd,
  output logic        stall_out,
  output logic [31:0] dmem_addr,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [2:0]  f3_reg;
  logic [4:0]  rd_reg;
  logic [1:0]  off_reg;

  logic        is_mem;
  logic [1:0]  size;
  logic        f3_bad;
  logic        mis;
  logic        trap;
  logic        accept;
  logic [1:0]  off;
  logic [3:0]  mbe;
  logic [31:0] wdata;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  // Decode the incoming slot: access size, legality, lane offset and store lanes.
  always_comb begin
    is_mem = ex_load | ex_store;
    size   = ex_funct3[1:0];
    if (ex_load)
      f3_bad = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
    else
      f3_bad = (ex_funct3 > 3'b010);
    mis = ((size == 2'b01) && ex_alu_out[0]) ||
          (size[1] && (ex_alu_out[1:0] != 2'b00));
    trap = ADDR_CHECK && is_mem && (f3_bad || mis);
    // Offset is forced to natural alignment; only matters when checking is off,
    // since a misaligned access traps otherwise.
    case (size)
      2'b00:   off = ex_alu_out[1:0];
      2'b01:   off = {ex_alu_out[1], 1'b0};
      default: off = 2'b00;
    endcase
    case (size)
      2'b00:   mbe = 4'b0001 << off;
      2'b01:   mbe = 4'b0011 << off;
      default: mbe = 4'hF;
    endcase
    wdata  = ex_rs2 << {off, 3'b000};
    accept = (state == IDLE) && ex_valid && is_mem && !trap;
  end

  // Upstream holds while a legal access is being accepted or is still pending.
  always_comb begin
    stall_out = !rst && (accept || ((state == ACCESS) && !dmem_resp));
  end

  // Extract the addressed byte/half from the read word and extend it.
  always_comb begin
    shifted = dmem_rdata >> {off_reg, 3'b000};
    case (f3_reg)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'h0, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_data = {16'h0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // IDLE/ACCESS sequencing, request registers and the MEM/WB slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      f3_reg       <= 3'b000;
      rd_reg       <= 5'd0;
      off_reg      <= 2'b00;
      dmem_addr    <= 32'h0;
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_mbe     <= 4'h0;
      dmem_wdata   <= 32'h0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          wb_valid <= 1'b0;
          wb_we    <= 1'b0;
          wb_data  <= 32'h0;
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= ex_wb_en && (ex_rd != 5'd0);
              wb_rd    <= ex_rd;
              wb_data  <= ex_alu_out;
            end else if (trap) begin
              wb_valid     <= 1'b1;
              wb_rd        <= ex_rd;
              misalign_err <= 1'b1;
            end else begin
              dmem_addr  <= {ex_alu_out[31:2], 2'b00};
              dmem_read  <= ex_load;
              dmem_write <= ex_store;
              dmem_mbe   <= ex_store ? mbe : 4'h0;
              dmem_wdata <= ex_store ? wdata : 32'h0;
              f3_reg     <= ex_funct3;
              rd_reg     <= ex_rd;
              off_reg    <= off;
              state      <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            state      <= IDLE;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            dmem_mbe   <= 4'h0;
            wb_valid   <= 1'b1;
            wb_rd      <= rd_reg;
            if (dmem_read) begin
              wb_we   <= (rd_reg != 5'd0);
              wb_data <= ld_data;
            end else begin
              wb_we   <= 1'b0;
              wb_data <= 32'h0;
            end
          end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a byte-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store, ex_wb_en;
  logic [31:0] ex_alu_out, ex_rs2;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        stall_out, dmem_read, dmem_write, dmem_resp;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_mbe;
  logic        wb_valid, wb_we, misalign_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // second instance with address checking disabled, driven only in one case
  logic        ex_valid1, dmem_resp1;
  logic        stall_out1, dmem_read1, dmem_write1, wb_valid1, wb_we1, misalign_err1;
  logic [31:0] dmem_addr1, dmem_wdata1, wb_data1;
  logic [3:0]  dmem_mbe1;
  logic [4:0]  wb_rd1;

  int total = 0;
  int bad   = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_rs2(ex_rs2), .ex_funct3(ex_funct3), .ex_load(ex_load), .ex_store(ex_store),
    .ex_wb_en(ex_wb_en), .ex_rd(ex_rd), .stall_out(stall_out), .dmem_addr(dmem_addr),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_mbe(dmem_mbe),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err)
  );

  mem_stage #(.ADDR_CHECK(1'b0)) dut_nochk (
    .clk(clk), .rst(rst), .ex_valid(ex_valid1), .ex_alu_out(ex_alu_out),
    .ex_rs2(ex_rs2), .ex_funct3(ex_funct3), .ex_load(ex_load), .ex_store(ex_store),
    .ex_wb_en(ex_wb_en), .ex_rd(ex_rd), .stall_out(stall_out1), .dmem_addr(dmem_addr1),
    .dmem_read(dmem_read1), .dmem_write(dmem_write1), .dmem_mbe(dmem_mbe1),
    .dmem_wdata(dmem_wdata1), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp1),
    .wb_valid(wb_valid1), .wb_we(wb_we1), .wb_rd(wb_rd1), .wb_data(wb_data1),
    .misalign_err(misalign_err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic bit tb_trap(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a);
    bit ok;
    int n;
    if (!(ld || st)) return 1'b0;
    if (ld) ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else    ok = f3 inside {3'b000, 3'b001, 3'b010};
    if (!ok) return 1'b1;
    n = 1 << f3[1:0];
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [31:0] tb_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rdata);
    logic [7:0]  b [4];
    logic [7:0]  top;
    logic [31:0] v;
    int off, n;
    off = int'(a[1:0]);
    n   = 1 << f3[1:0];
    v   = 32'h0;
    for (int i = 0; i < 4; i++) b[i] = rdata[8*i +: 8];
    for (int i = 0; i < n; i++) v = v | (32'(b[off+i]) << (8*i));
    top = b[off+n-1];
    if (!f3[2] && n < 4 && top[7])
      for (int i = n; i < 4; i++) v = v | (32'hFF << (8*i));
    return v;
  endfunction

  function automatic logic [3:0] tb_mbe(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    int off, n;
    off = int'(a[1:0]);
    n   = 1 << f3[1:0];
    m   = 4'h0;
    for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + n);
    return m;
  endfunction

  function automatic logic [31:0] tb_wdata(input logic [31:0] a, input logic [31:0] rs2);
    logic [31:0] w;
    int off;
    off = int'(a[1:0]);
    w   = 32'h0;
    for (int i = 0; i < 4; i++)
      if (i >= off) w[8*i +: 8] = rs2[8*(i-off) +: 8];
    return w;
  endfunction

  // ---------------- behavioural model state ----------------
  logic        m_busy, p_load;
  logic [2:0]  p_f3;
  logic [4:0]  p_rd;
  logic [31:0] p_addr, p_rs2;
  logic        e_wbv, e_we, e_err;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  // Model: what the WB slot must hold after each edge, and the pending access.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; p_load <= 1'b0; p_f3 <= 3'b0; p_rd <= 5'd0;
      p_addr <= 32'h0; p_rs2 <= 32'h0;
      e_wbv <= 1'b0; e_we <= 1'b0; e_err <= 1'b0; e_rd <= 5'd0; e_data <= 32'h0;
    end else begin
      e_err <= 1'b0;
      if (!m_busy) begin
        if (!ex_valid) begin
          e_wbv <= 1'b0; e_we <= 1'b0;
        end else if (!(ex_load || ex_store)) begin
          e_wbv <= 1'b1; e_we <= ex_wb_en && (ex_rd != 5'd0);
          e_rd <= ex_rd; e_data <= ex_alu_out;
        end else if (tb_trap(ex_load, ex_store, ex_funct3, ex_alu_out)) begin
          e_wbv <= 1'b1; e_we <= 1'b0; e_err <= 1'b1;
        end else begin
          m_busy <= 1'b1; e_wbv <= 1'b0; e_we <= 1'b0;
          p_load <= ex_load; p_f3 <= ex_funct3; p_rd <= ex_rd;
          p_addr <= ex_alu_out; p_rs2 <= ex_rs2;
        end
      end else if (dmem_resp) begin
        m_busy <= 1'b0; e_wbv <= 1'b1; e_rd <= p_rd;
        if (p_load) begin
          e_we <= (p_rd != 5'd0); e_data <= tb_load(p_f3, p_addr, dmem_rdata);
        end else begin
          e_we <= 1'b0; e_data <= 32'h0;
        end
      end else begin
        e_wbv <= 1'b0; e_we <= 1'b0;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin : cmp
    logic es;
    if (!rst && run_chk) begin
      if (m_busy) es = !dmem_resp;
      else es = ex_valid && (ex_load || ex_store) &&
                !tb_trap(ex_load, ex_store, ex_funct3, ex_alu_out);
      chk("stall_out", stall_out, es);
      chk("wb_valid", wb_valid, e_wbv);
      chk("wb_we", wb_we, e_we);
      chk("misalign_err", misalign_err, e_err);
      if (e_wbv && !e_err) chk("wb_data", wb_data, e_data);
      if (e_we) chk("wb_rd", wb_rd, e_rd);
      chk("dmem_read", dmem_read, m_busy && p_load);
      chk("dmem_write", dmem_write, m_busy && !p_load);
      if (m_busy) begin
        chk("dmem_addr", dmem_addr, {p_addr[31:2], 2'b00});
        chk("dmem_mbe", dmem_mbe, p_load ? 4'h0 : tb_mbe(p_f3, p_addr));
        if (!p_load) chk("dmem_wdata", dmem_wdata, tb_wdata(p_addr, p_rs2));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] rs2,
                       input bit wben, input logic [4:0] rd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_alu_out = a; ex_rs2 = rs2; ex_wb_en = wben; ex_rd = rd;
  endtask

  task automatic respond(input logic [31:0] rdata);
    dmem_rdata = rdata; dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0; ex_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, stall_out, 1'b0);
    chk({tag, "_rd"}, dmem_read, 1'b0);
    chk({tag, "_wr"}, dmem_write, 1'b0);
    chk({tag, "_mbe"}, dmem_mbe, 4'h0);
    chk({tag, "_addr"}, dmem_addr, 32'h0);
    chk({tag, "_wdata"}, dmem_wdata, 32'h0);
    chk({tag, "_wbv"}, wb_valid, 1'b0);
    chk({tag, "_wbwe"}, wb_we, 1'b0);
    chk({tag, "_wbrd"}, wb_rd, 5'd0);
    chk({tag, "_wbdata"}, wb_data, 32'h0);
    chk({tag, "_err"}, misalign_err, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_wb_en = 1'b0;
    ex_alu_out = 32'h0; ex_rs2 = 32'h0; ex_funct3 = 3'b0; ex_rd = 5'd0;
    dmem_rdata = 32'h0; dmem_resp = 1'b0; ex_valid1 = 1'b0; dmem_resp1 = 1'b0;

    // reset state, with a legal load presented to show stall stays low
    step();
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 5'd1);
    step();
    chk_zero("reset");
    ex_valid = 1'b0;
    rst = 1'b0;
    run_chk = 1'b1;
    step();

    // ALU passthrough
    drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 1'b1, 5'd5);
    step();
    chk("pass_valid", wb_valid, 1'b1); chk("pass_we", wb_we, 1'b1);
    chk("pass_rd", wb_rd, 5'd5); chk("pass_data", wb_data, 32'h1234);
    ex_rd = 5'd0;
    step();
    chk("pass_rd0_we", wb_we, 1'b0);
    ex_valid = 1'b0;
    step();

    // lb sign extend, response in the third ACCESS cycle
    drive(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 1'b0, 5'd7);
    #1 chk("lb_stall_accept", stall_out, 1'b1);
    step();
    chk("lb_addr", dmem_addr, 32'h1000); chk("lb_read1", dmem_read, 1'b1);
    chk("lb_stall1", stall_out, 1'b1);
    step();
    chk("lb_read2", dmem_read, 1'b1); chk("lb_stall2", stall_out, 1'b1);
    step();
    dmem_rdata = 32'h80FF_FF7F; dmem_resp = 1'b1;
    #1 chk("lb_read3", dmem_read, 1'b1); chk("lb_stall_resp", stall_out, 1'b0);
    step();
    dmem_resp = 1'b0; ex_valid = 1'b0;
    chk("lb_wbv", wb_valid, 1'b1); chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_we", wb_we, 1'b1); chk("lb_read_off", dmem_read, 1'b0);

    // lhu then lh, back to back
    drive(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 1'b0, 5'd8);
    step();
    respond(32'h9ABC_0000);
    chk("lhu_data", wb_data, 32'h0000_9ABC);
    drive(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 1'b0, 5'd8);
    step();
    respond(32'h9ABC_0000);
    chk("lh_data", wb_data, 32'hFFFF_9ABC);

    // stores
    drive(1'b0, 1'b1, 3'b000, 32'h3001, 32'h0000_00AA, 1'b0, 5'd3);
    step();
    chk("sb_mbe", dmem_mbe, 4'b0010); chk("sb_wdata", dmem_wdata, 32'h0000_AA00);
    chk("sb_write", dmem_write, 1'b1);
    respond(32'h0);
    chk("sb_wbv", wb_valid, 1'b1); chk("sb_we", wb_we, 1'b0);
    drive(1'b0, 1'b1, 3'b001, 32'h3002, 32'h0000_1234, 1'b0, 5'd3);
    step();
    chk("sh_mbe", dmem_mbe, 4'b1100); chk("sh_wdata", dmem_wdata, 32'h1234_0000);
    respond(32'h0);
    chk("sh_we", wb_we, 1'b0);
    drive(1'b0, 1'b1, 3'b010, 32'h3004, 32'hDEAD_BEEF, 1'b0, 5'd3);
    step();
    chk("sw_mbe", dmem_mbe, 4'hF); chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    respond(32'h0);
    chk("sw_we", wb_we, 1'b0);

    // misaligned lw; the unchecked instance issues an aligned read instead
    drive(1'b1, 1'b0, 3'b010, 32'h4002, 32'h0, 1'b0, 5'd9);
    ex_valid1 = 1'b1;
    #1 chk("mis_stall", stall_out, 1'b0);
    step();
    chk("mis_read", dmem_read, 1'b0); chk("mis_wbv", wb_valid, 1'b1);
    chk("mis_we", wb_we, 1'b0); chk("mis_err", misalign_err, 1'b1);
    chk("nochk_read", dmem_read1, 1'b1); chk("nochk_addr", dmem_addr1, 32'h4000);
    ex_valid = 1'b0; ex_valid1 = 1'b0; dmem_resp1 = 1'b1;
    step();
    dmem_resp1 = 1'b0;
    chk("mis_err_pulse", misalign_err, 1'b0);
    chk("nochk_wbv", wb_valid1, 1'b1);

    // reset in the middle of an access
    drive(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 1'b0, 5'd4);
    step();
    ex_valid = 1'b0;
    chk("rst_pre_read", dmem_read, 1'b1);
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    step();
    rst = 1'b0;
    dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
    step();
    dmem_resp = 1'b0;
    chk("stray_resp_wbv", wb_valid, 1'b0);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        ex_valid = 1'b0;
        dmem_resp = 1'($urandom); dmem_rdata = $urandom;
        step();
        dmem_resp = 1'b0;
      end else begin
        logic ld, st;
        logic [2:0] f3;
        logic [31:0] a;
        ld = (kind >= 4) && (kind < 7);
        st = (kind >= 7);
        f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
        a  = $urandom;
        drive(ld, st, f3, a, $urandom, 1'($urandom), 5'($urandom));
        if ((ld || st) && !tb_trap(ld, st, f3, a)) begin
          int d;
          d = $urandom_range(0, 3);
          step();
          repeat (d) step();
          respond($urandom);
        end else begin
          step();
        end
        if ($urandom_range(0, 3) == 0) ex_valid = 1'b0;
      end
    end
    ex_valid = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
